// File: rtl/cpu_common_pkg.sv
// Shared CPU front-end types: fetch reasons, fetch FSM states and the
// fetched-instruction buffer entry layout.
package cpu_common;

    // Widest PC any core in this family uses; buffer entries carry this width.
    localparam int unsigned CPU_XLEN_MAX = 64;

    typedef enum logic [1:0] {
        IF_PREFETCH   = 2'd0,
        IF_MISPREDICT = 2'd1,
        IF_FENCEI     = 2'd2,
        IF_TRAP       = 2'd3
    } if_reason_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [CPU_XLEN_MAX-1:0] pc;
        logic [31:0]             instr;
        logic                    exception;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Fetched-instruction buffer: power-of-two depth circular FIFO with flush.
// Push and pop may occur together, including while full.
module if_fetch_fifo
    import cpu_common::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    fetch_entry_t  mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_FULL);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    // A pop while full frees the slot the concurrent push lands in.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy next-state; flush clears everything.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_ONE;
            if (do_pop)  rptr_d = rptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage; contents are meaningless until the count covers them.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one outstanding I-cache request at a time, a small
// buffer toward decode, and redirect handling that discards stale responses.
// Build option: IF_FETCH_RVC_EN enables 16-bit compressed instruction
// stepping (PC advances by 2 for non-32-bit encodings, 2-byte redirect
// alignment). Without it every instruction is 4 bytes and redirects are
// 4-byte aligned.
module if_fetch_unit
    import cpu_common::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    // privilege state and cache maintenance, passed straight through
    input  logic [1:0]        prv_i,
    input  logic              sum_i,
    input  logic [XLEN-1:0]   atp_i,
    input  logic              flush_cache_i,
    input  logic              flush_tlb_i,
    // redirect
    input  logic              redirect_valid_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    input  if_reason_t        redirect_reason_i,
    // decode handshake
    output logic              fetch_valid_o,
    input  logic              fetch_ready_i,
    output logic [XLEN-1:0]   fetch_pc_o,
    output logic [31:0]       fetch_instr_o,
    output logic              fetch_exception_o,
    // instruction cache, initiator side
    output logic              cache_req_valid_o,
    output logic [XLEN-1:0]   cache_req_pc_o,
    output if_reason_t        cache_req_reason_o,
    output logic [1:0]        cache_req_prv_o,
    output logic              cache_req_sum_o,
    output logic [XLEN-1:0]   cache_req_atp_o,
    output logic              cache_flush_cache_o,
    output logic              cache_flush_tlb_o,
    input  logic              cache_resp_valid_i,
    input  logic [XLEN-1:0]   cache_resp_pc_i,
    input  logic [31:0]       cache_resp_instr_i,
    input  logic              cache_resp_exception_i
);

    localparam int unsigned   CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FIFO_DEPTH - 1);

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
`ifdef IF_FETCH_RVC_EN
        return pc & ~XLEN'(1);
`else
        return pc & ~XLEN'(3);
`endif
    endfunction

    function automatic logic [XLEN-1:0] step_pc(input logic [XLEN-1:0] pc,
                                                 input logic compressed);
        return compressed ? pc + XLEN'(2) : pc + XLEN'(4);
    endfunction

    fetch_state_e  state_q, state_d;
    logic          discard_q, discard_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    if_reason_t    pend_reason_q, pend_reason_d;

    logic          req_valid;
    logic [XLEN-1:0] req_pc;
    if_reason_t    req_reason;
    logic          push;
    logic          rvc_w;
    logic [XLEN-1:0] npc_w;
    logic          slot_after;
    fetch_entry_t  push_entry, head_entry;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

`ifdef IF_FETCH_RVC_EN
    assign rvc_w = (cache_resp_instr_i[1:0] != 2'b11);
`else
    assign rvc_w = 1'b0;
`endif
    assign npc_w = step_pc(cache_resp_pc_i, rvc_w);

    // Pushing one entry leaves room for another if decode pops this cycle or
    // the buffer held fewer than DEPTH-1 entries beforehand.
    assign slot_after = (fetch_valid_o && fetch_ready_i) || (fifo_count < CNT_LAST);

    assign push_entry.pc        = CPU_XLEN_MAX'(cache_resp_pc_i);
    assign push_entry.instr     = cache_resp_exception_i ? {16'h0000, cache_resp_instr_i[15:0]}
                                                         : cache_resp_instr_i;
    assign push_entry.exception = cache_resp_exception_i;

    if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .pop_i   (fetch_ready_i),
        .flush_i (redirect_valid_i),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign fetch_valid_o     = !fifo_empty;
    assign fetch_pc_o        = head_entry.pc[XLEN-1:0];
    assign fetch_instr_o     = head_entry.instr;
    assign fetch_exception_o = head_entry.exception;

    // No request may leave while reset is held, whatever redirect does.
    assign cache_req_valid_o   = req_valid && rstn;
    assign cache_req_pc_o      = req_pc;
    assign cache_req_reason_o  = req_reason;
    assign cache_req_prv_o     = prv_i;
    assign cache_req_sum_o     = sum_i;
    assign cache_req_atp_o     = atp_i;
    assign cache_flush_cache_o = flush_cache_i;
    assign cache_flush_tlb_o   = flush_tlb_i;

    // FSM state and discard flag, asynchronously reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    // PC bookkeeping; only meaningful once the FSM has left IDLE.
    always_ff @(posedge clk) begin
        pc_q          <= pc_d;
        pend_pc_q     <= pend_pc_d;
        pend_reason_q <= pend_reason_d;
    end

    // Next-state: redirects always restart fetch; a redirect racing an
    // outstanding request is parked until the stale response shows up.
    always_comb begin
        state_d       = state_q;
        discard_d     = discard_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        pend_reason_d = pend_reason_q;
        case (state_q)
            IDLE: begin
                if (redirect_valid_i) state_d = BUSY;
            end
            BUSY: begin
                if (redirect_valid_i) begin
                    if (cache_resp_valid_i) begin
                        discard_d = 1'b0;
                    end else begin
                        discard_d     = 1'b1;
                        pend_pc_d     = align_pc(redirect_pc_i);
                        pend_reason_d = redirect_reason_i;
                    end
                end else if (cache_resp_valid_i) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else if (cache_resp_exception_i) begin
                        state_d = HALT;
                    end else begin
                        pc_d = npc_w;
                        if (!slot_after) state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (redirect_valid_i || !fifo_full) state_d = BUSY;
            end
            HALT: begin
                if (redirect_valid_i) state_d = BUSY;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: request issue and buffer push for the current state.
    always_comb begin
        req_valid  = 1'b0;
        req_pc     = align_pc(redirect_pc_i);
        req_reason = redirect_reason_i;
        push       = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (redirect_valid_i) req_valid = 1'b1;
            end
            WAIT: begin
                if (redirect_valid_i) begin
                    req_valid = 1'b1;
                end else if (!fifo_full) begin
                    req_valid  = 1'b1;
                    req_pc     = pc_q;
                    req_reason = IF_PREFETCH;
                end
            end
            BUSY: begin
                if (redirect_valid_i) begin
                    req_valid = cache_resp_valid_i;
                end else if (cache_resp_valid_i) begin
                    if (discard_q) begin
                        req_valid  = 1'b1;
                        req_pc     = pend_pc_q;
                        req_reason = pend_reason_q;
                    end else begin
                        push = 1'b1;
                        if (!cache_resp_exception_i && slot_after) begin
                            req_valid  = 1'b1;
                            req_pc     = npc_w;
                            req_reason = IF_PREFETCH;
                        end
                    end
                end
            end
            default: req_valid = 1'b0;
        endcase
    end

endmodule
